// File: rtl/sr_banked_register.sv
// rtl/sr_banked_register.sv - status flags with masked load, banked saved-status and ARM condition evaluator
// Optional macro SR_COND_FWD_EN: condition evaluator sees next-state flags instead of registered flags.
module sr_banked_register #(
   parameter int FLAG_W    = 4,
   parameter int NUM_BANKS = 4,
   parameter int BANK_W    = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [FLAG_W-1:0] cc_in,
   input  logic [FLAG_W-1:0] cc_mask,
   input  logic              S,
   input  logic              exc_entry,
   input  logic [BANK_W-1:0] exc_bank,
   input  logic              exc_return,
   input  logic              cond_req,
   input  logic [3:0]        cond_in,
   output logic [FLAG_W-1:0] cc_out,
   output logic [BANK_W-1:0] active_bank,
   output logic              cond_valid,
   output logic              cond_true,
   output logic              err
);

   logic [FLAG_W-1:0] cc_q, cc_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [FLAG_W-1:0] saved_q [NUM_BANKS];
   logic [FLAG_W-1:0] saved_d [NUM_BANKS];
   logic              err_q, err_d;
   logic              cv_q, cv_d;
   logic              ct_q, ct_d;
   logic              entry_ok;
   logic [3:0]        eval_flags;

   // Flags are N,Z,C,V in bits 3..0.
   function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (code)
         4'h0:    cond_eval = z;
         4'h1:    cond_eval = !z;
         4'h2:    cond_eval = c;
         4'h3:    cond_eval = !c;
         4'h4:    cond_eval = n;
         4'h5:    cond_eval = !n;
         4'h6:    cond_eval = v;
         4'h7:    cond_eval = !v;
         4'h8:    cond_eval = c && !z;
         4'h9:    cond_eval = !c || z;
         4'hA:    cond_eval = (n == v);
         4'hB:    cond_eval = (n != v);
         4'hC:    cond_eval = !z && (n == v);
         4'hD:    cond_eval = z || (n != v);
         4'hE:    cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   // Nesting is unsupported, so entry is only legal from the user bank.
   assign entry_ok = (bank_q == '0) && (exc_bank != '0) && (int'(exc_bank) < NUM_BANKS);

   always_comb begin
      cc_d    = cc_q;
      bank_d  = bank_q;
      saved_d = saved_q;
      err_d   = 1'b0;
      if (exc_entry) begin
         if (entry_ok) begin
            saved_d[exc_bank] = cc_q;
            bank_d            = exc_bank;
         end else begin
            err_d = 1'b1;
         end
      end else if (exc_return) begin
         if (bank_q != '0) begin
            cc_d   = saved_q[bank_q];
            bank_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (S) begin
         cc_d = (cc_q & ~cc_mask) | (cc_in & cc_mask);
      end
   end

`ifdef SR_COND_FWD_EN
   assign eval_flags = cc_d[3:0];
`else
   assign eval_flags = cc_q[3:0];
`endif

   always_comb begin
      cv_d = cond_req;
      ct_d = cond_req && cond_eval(cond_in, eval_flags);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cc_q   <= '0;
         bank_q <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            saved_q[b] <= '0;
         end
         err_q  <= 1'b0;
         cv_q   <= 1'b0;
         ct_q   <= 1'b0;
      end else begin
         cc_q    <= cc_d;
         bank_q  <= bank_d;
         saved_q <= saved_d;
         err_q   <= err_d;
         cv_q    <= cv_d;
         ct_q    <= ct_d;
      end
   end

   assign cc_out      = cc_q;
   assign active_bank = bank_q;
   assign cond_valid  = cv_q;
   assign cond_true   = ct_q;
   assign err         = err_q;

endmodule

// File: tb/tb_sr_banked_register.sv
// tb/tb_sr_banked_register.sv - scoreboard bench for sr_banked_register
module tb_sr_banked_register;

`ifdef SR_COND_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   logic       CLK;
   logic       RESET;
   logic [3:0] cc_in, cc_mask;
   logic       S, exc_entry, exc_return, cond_req;
   logic [1:0] exc_bank;
   logic [3:0] cond_in;
   logic [3:0] cc_out;
   logic [1:0] active_bank;
   logic       cond_valid, cond_true, err;

   typedef struct packed {
      logic [3:0] cc;
      logic [1:0] bank;
      logic       err;
      logic       cv;
   } exp_t;

   exp_t st_q[$];
   logic cond_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   sr_banked_register dut (
      .CLK(CLK), .RESET(RESET), .cc_in(cc_in), .cc_mask(cc_mask), .S(S),
      .exc_entry(exc_entry), .exc_bank(exc_bank), .exc_return(exc_return),
      .cond_req(cond_req), .cond_in(cond_in), .cc_out(cc_out),
      .active_bank(active_bank), .cond_valid(cond_valid), .cond_true(cond_true), .err(err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Independent reference: odd codes invert the even-code predicate.
   function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
      logic base;
      case (code[3:1])
         3'd0: base = f[2];
         3'd1: base = f[1];
         3'd2: base = f[3];
         3'd3: base = f[0];
         3'd4: base = f[1] & ~f[2];
         3'd5: base = ~(f[3] ^ f[0]);
         3'd6: base = ~f[2] & ~(f[3] ^ f[0]);
         default: base = 1'b1;
      endcase
      return code[0] ? ~base : base;
   endfunction

   task automatic drive(input logic s, input logic [3:0] ci, input logic [3:0] cm,
                        input logic ent, input logic [1:0] eb, input logic ret,
                        input logic cr, input logic [3:0] cn,
                        input logic [3:0] ecc, input logic [1:0] ebk, input logic eerr, input logic ect);
      exp_t e;
      @(negedge CLK);
      S = s; cc_in = ci; cc_mask = cm; exc_entry = ent; exc_bank = eb;
      exc_return = ret; cond_req = cr; cond_in = cn;
      e.cc = ecc; e.bank = ebk; e.err = eerr; e.cv = cr;
      st_q.push_back(e);
      if (cr) cond_q.push_back(ect);
   endtask

   task automatic idle_inputs();
      S = 0; cc_in = 0; cc_mask = 0; exc_entry = 0; exc_bank = 0;
      exc_return = 0; cond_req = 0; cond_in = 0;
   endtask

   // Monitor: one expected state per driven cycle, one cond result per cond_valid.
   always @(posedge CLK) begin
      #1;
      if (st_q.size() > 0) begin
         exp_t e;
         logic ec;
         e = st_q.pop_front();
         chk("cc_out", 32'(cc_out), 32'(e.cc));
         chk("active_bank", 32'(active_bank), 32'(e.bank));
         chk("err", 32'(err), 32'(e.err));
         chk("cond_valid", 32'(cond_valid), 32'(e.cv));
         if (cond_valid) begin
            if (cond_q.size() == 0) begin
               chk("cond_unexpected", 32'd1, 32'd0);
            end else begin
               ec = cond_q.pop_front();
               chk("cond_true", 32'(cond_true), 32'(ec));
            end
         end else begin
            chk("cond_true_idle", 32'(cond_true), 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      chk("rst_cc", 32'(cc_out), 0);
      chk("rst_bank", 32'(active_bank), 0);
      chk("rst_cv", 32'(cond_valid), 0);
      chk("rst_err", 32'(err), 0);
      @(negedge CLK);
      RESET = 1'b0;

      //     S  ci    cm    ent eb ret cr cn    ecc   ebk err ct
      drive(1, 4'hF, 4'h5, 0, 0, 0, 0, 4'h0, 4'h5, 0, 0, 0);   // masked load
      drive(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h5, 0, 0, 0);   // mask 0 no-op
      drive(1, 4'h9, 4'hF, 0, 0, 0, 0, 4'h0, 4'h9, 0, 0, 0);
      drive(0, 4'h0, 4'h0, 1, 2, 0, 0, 4'h0, 4'h9, 2, 0, 0);   // entry bank 2
      drive(1, 4'h6, 4'hF, 0, 0, 0, 0, 4'h0, 4'h6, 2, 0, 0);
      drive(1, 4'h0, 4'hF, 0, 0, 1, 0, 4'h0, 4'h9, 0, 0, 0);   // return beats S
      drive(0, 4'h0, 4'h0, 0, 0, 1, 0, 4'h0, 4'h9, 0, 1, 0);   // return from user
      drive(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h9, 0, 0, 0);
      drive(0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h9, 1, 0, 0);
      drive(1, 4'h0, 4'hF, 1, 3, 0, 0, 4'h0, 4'h9, 1, 1, 0);   // nested entry
      drive(1, 4'h3, 4'hF, 0, 0, 0, 0, 4'h0, 4'h3, 1, 0, 0);
      drive(0, 4'h0, 4'h0, 0, 0, 1, 0, 4'h0, 4'h9, 0, 0, 0);
      drive(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'h9, 0, 1, 0);   // entry to bank 0
      drive(1, 4'h3, 4'hF, 0, 0, 0, 0, 4'h0, 4'h3, 0, 0, 0);
      drive(1, 4'hC, 4'hF, 1, 3, 0, 0, 4'h0, 4'h3, 3, 0, 0);   // entry beats S
      drive(1, 4'hC, 4'hF, 0, 0, 0, 0, 4'h0, 4'hC, 3, 0, 0);
      drive(0, 4'h0, 4'h0, 0, 0, 1, 0, 4'h0, 4'h3, 0, 0, 0);
      drive(1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
      drive(1, 4'h4, 4'hF, 0, 0, 0, 1, 4'h0, 4'h4, 0, 0, FWD);  // EQ with same-cycle load
      drive(0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h4, 1, 0, 0);
      drive(1, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0, 0);
      drive(0, 4'h0, 4'h0, 0, 0, 1, 1, 4'h1, 4'h4, 0, 0, !FWD); // NE with same-cycle restore
      drive(0, 4'h0, 4'h0, 1, 2, 0, 1, 4'hE, 4'h4, 2, 0, 1);

      // Asynchronous reset mid-cycle while in bank 2 with cond_valid high.
      @(posedge CLK);
      #3;
      RESET = 1'b1;
      #1;
      chk("arst_cc", 32'(cc_out), 0);
      chk("arst_bank", 32'(active_bank), 0);
      chk("arst_cv", 32'(cond_valid), 0);
      @(negedge CLK);
      RESET = 1'b0;
      idle_inputs();

      for (int v = 0; v < 16; v++) begin
         drive(1, 4'(v), 4'hF, 0, 0, 0, 0, 4'h0, 4'(v), 0, 0, 0);
         for (int c = 0; c < 16; c++) begin
            drive(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'(c), 4'(v), 0, 0, ref_cond(4'(c), 4'(v)));
         end
      end

      @(negedge CLK);
      idle_inputs();
      repeat (3) @(negedge CLK);
      chk("st_q_drained", 32'(st_q.size()), 0);
      chk("cond_q_drained", 32'(cond_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
